// File: rtl/decode_issue_stage.sv
// -----------------------------------------------------------------------------
// decode_issue_stage
//
// Instruction decode/issue stage sitting directly in front of the 32x32
// register bank. The incoming instruction is decoded combinationally. Its
// source fields drive the bank read addresses, and the bank returns operands
// in the same cycle. Pending register writes are tracked in a busy
// scoreboard, and the stage stalls on RAW/WAW hazards. Decoded control and
// captured operands go to EX through a single output register.
//
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high. Ready never depends on valid from the same side. A producer that
// raises valid keeps its payload stable until the transfer. On the IF side,
// if_ready is computed from flush, the hazard check and output-register
// occupancy. On the EX side, ex_valid and the ex_* payload stay frozen while
// ex_ready is low. flush overrides an EX handoff: the entry is dropped and is
// not counted as handed off.
//
// Optional feature (macro WB_BYPASS_EN): when defined, a writeback that
// targets a busy source or destination in the same cycle clears that
// register's hazard immediately. wb_data is then forwarded into the captured
// operand. When the macro is undefined, wb_data is ignored and a cleared
// register becomes usable one cycle after wb_valid.
//
// Ports:
//   clock, reset            clock; asynchronous active-high reset
//   if_valid/if_ready       IF handshake; if_instr/if_pc are the payload
//   RS, RT, read_reg        bank read addresses and read-request flag
//   data_1, data_2          bank read data for RS/RT (same cycle)
//   ex_valid/ex_ready       EX handshake; ex_* are the registered payload
//   wb_valid/wb_dest/wb_data writeback that releases a busy register
//   flush                   drop the output-register entry; blocks IF
//   o_dbg_busy              scoreboard busy vector (debug observation)
// -----------------------------------------------------------------------------
module decode_issue_stage #(
    parameter int DATA_WIDTH         = 32,
    parameter int NUM_REGS           = 32,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [31:0]           if_instr,
    input  logic [DATA_WIDTH-1:0] if_pc,
    output logic [4:0]            RS,
    output logic [4:0]            RT,
    output logic                  read_reg,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [DATA_WIDTH-1:0] data_2,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [5:0]            ex_op,
    output logic [5:0]            ex_funct,
    output logic [DATA_WIDTH-1:0] ex_rs_val,
    output logic [DATA_WIDTH-1:0] ex_rt_val,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [4:0]            ex_dest,
    output logic                  ex_wen,
    output logic [DATA_WIDTH-1:0] ex_pc,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic [NUM_REGS-1:0]   o_dbg_busy
);

    // A register takes part in hazard tracking unless it is the hardwired r0.
    function automatic logic f_tracked(input logic [4:0] a);
        return (ZERO_REG_HARDWIRED == 0) || (a != 5'd0);
    endfunction

    // ---------------- field extraction and decode ----------------
    logic [5:0]            w_op;
    logic [4:0]            w_rs;
    logic [4:0]            w_rt;
    logic [4:0]            w_rd;
    logic [15:0]           w_imm16;
    logic                  w_rd_rs;
    logic                  w_rd_rt;
    logic                  w_wen;
    logic [4:0]            w_dest;
    logic [DATA_WIDTH-1:0] w_imm;

    assign w_op    = if_instr[31:26];
    assign w_rs    = if_instr[25:21];
    assign w_rt    = if_instr[20:16];
    assign w_rd    = if_instr[15:11];
    assign w_imm16 = if_instr[15:0];

    always_comb begin
        w_rd_rs = 1'b0;
        w_rd_rt = 1'b0;
        w_wen   = 1'b0;
        w_dest  = 5'd0;
        w_imm   = '0;
        case (w_op)
            6'h00: begin                                   // R-type
                w_rd_rs = 1'b1;
                w_rd_rt = 1'b1;
                w_wen   = 1'b1;
                w_dest  = w_rd;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23: begin       // addi..sltiu, lw
                w_rd_rs = 1'b1;
                w_wen   = 1'b1;
                w_dest  = w_rt;
                w_imm   = {{(DATA_WIDTH-16){w_imm16[15]}}, w_imm16};
            end
            6'h0C, 6'h0D, 6'h0E: begin                     // andi/ori/xori
                w_rd_rs = 1'b1;
                w_wen   = 1'b1;
                w_dest  = w_rt;
                w_imm   = {{(DATA_WIDTH-16){1'b0}}, w_imm16};
            end
            6'h0F: begin                                   // lui
                w_wen   = 1'b1;
                w_dest  = w_rt;
                w_imm   = {w_imm16, {(DATA_WIDTH-16){1'b0}}};
            end
            6'h2B, 6'h04, 6'h05: begin                     // sw, beq, bne
                w_rd_rs = 1'b1;
                w_rd_rt = 1'b1;
                w_imm   = {{(DATA_WIDTH-16){w_imm16[15]}}, w_imm16};
            end
            6'h02: begin                                   // j
                w_imm   = {{(DATA_WIDTH-26){1'b0}}, if_instr[25:0]};
            end
            default: begin                                 // unknown op: NOP
                w_rd_rs = 1'b0;
            end
        endcase
    end

    assign RS       = w_rs;
    assign RT       = w_rt;
    assign read_reg = if_valid && (w_rd_rs || w_rd_rt);

    // ---------------- state ----------------
    logic [NUM_REGS-1:0]   r_busy;
    logic                  r_ex_valid;
    logic [5:0]            r_ex_op;
    logic [5:0]            r_ex_funct;
    logic [DATA_WIDTH-1:0] r_ex_rs_val;
    logic [DATA_WIDTH-1:0] r_ex_rt_val;
    logic [DATA_WIDTH-1:0] r_ex_imm;
    logic [4:0]            r_ex_dest;
    logic                  r_ex_wen;
    logic [DATA_WIDTH-1:0] r_ex_pc;

    // ---------------- writeback bypass ----------------
    logic                  w_wb_hit_rs;
    logic                  w_wb_hit_rt;
    logic                  w_wb_hit_dst;
    logic [DATA_WIDTH-1:0] w_opnd_1;
    logic [DATA_WIDTH-1:0] w_opnd_2;

`ifdef WB_BYPASS_EN
    // A same-cycle writeback only matters for a register that is still busy.
    // Otherwise the bank already holds the committed value.
    assign w_wb_hit_rs  = wb_valid && f_tracked(wb_dest) && (wb_dest == w_rs) && r_busy[w_rs];
    assign w_wb_hit_rt  = wb_valid && f_tracked(wb_dest) && (wb_dest == w_rt) && r_busy[w_rt];
    assign w_wb_hit_dst = wb_valid && f_tracked(wb_dest) && (wb_dest == w_dest) && r_busy[w_dest];
    assign w_opnd_1     = (w_rd_rs && w_wb_hit_rs) ? wb_data : data_1;
    assign w_opnd_2     = (w_rd_rt && w_wb_hit_rt) ? wb_data : data_2;
`else
    logic w_unused_wb_data;
    assign w_wb_hit_rs      = 1'b0;
    assign w_wb_hit_rt      = 1'b0;
    assign w_wb_hit_dst     = 1'b0;
    assign w_opnd_1         = data_1;
    assign w_opnd_2         = data_2;
    assign w_unused_wb_data = ^wb_data;
`endif

    // ---------------- hazard detection ----------------
    // A register blocks issue if the scoreboard marks it busy, or if it is
    // the destination of the instruction currently waiting in the output
    // register. That instruction is not in the scoreboard until it hands off.
    logic w_haz_rs;
    logic w_haz_rt;
    logic w_haz_dst;
    logic w_stall;
    logic w_xfer;
    logic w_handoff;

    assign w_haz_rs  = w_rd_rs && f_tracked(w_rs) &&
                       ((r_busy[w_rs] && !w_wb_hit_rs) ||
                        (r_ex_valid && r_ex_wen && (r_ex_dest == w_rs)));
    assign w_haz_rt  = w_rd_rt && f_tracked(w_rt) &&
                       ((r_busy[w_rt] && !w_wb_hit_rt) ||
                        (r_ex_valid && r_ex_wen && (r_ex_dest == w_rt)));
    assign w_haz_dst = w_wen && f_tracked(w_dest) &&
                       ((r_busy[w_dest] && !w_wb_hit_dst) ||
                        (r_ex_valid && r_ex_wen && (r_ex_dest == w_dest)));
    assign w_stall   = w_haz_rs || w_haz_rt || w_haz_dst;

    assign if_ready  = !flush && !w_stall && (!r_ex_valid || ex_ready);
    assign w_xfer    = if_valid && if_ready;
    assign w_handoff = r_ex_valid && ex_ready && !flush;

    // ---------------- scoreboard ----------------
    // The set is applied after the clear, so set wins on a collision.
    logic [NUM_REGS-1:0] w_busy_next;

    always_comb begin
        w_busy_next = r_busy;
        if (wb_valid) begin
            w_busy_next[wb_dest] = 1'b0;
        end
        if (w_handoff && r_ex_wen && f_tracked(r_ex_dest)) begin
            w_busy_next[r_ex_dest] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_op     <= '0;
            r_ex_funct  <= '0;
            r_ex_rs_val <= '0;
            r_ex_rt_val <= '0;
            r_ex_imm    <= '0;
            r_ex_dest   <= '0;
            r_ex_wen    <= 1'b0;
            r_ex_pc     <= '0;
        end else if (flush) begin
            r_ex_valid  <= 1'b0;
        end else if (w_xfer) begin
            r_ex_valid  <= 1'b1;
            r_ex_op     <= w_op;
            r_ex_funct  <= if_instr[5:0];
            r_ex_rs_val <= w_opnd_1;
            r_ex_rt_val <= w_opnd_2;
            r_ex_imm    <= w_imm;
            r_ex_dest   <= w_dest;
            r_ex_wen    <= w_wen;
            r_ex_pc     <= if_pc;
        end else if (w_handoff) begin
            r_ex_valid  <= 1'b0;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_op      = r_ex_op;
    assign ex_funct   = r_ex_funct;
    assign ex_rs_val  = r_ex_rs_val;
    assign ex_rt_val  = r_ex_rt_val;
    assign ex_imm     = r_ex_imm;
    assign ex_dest    = r_ex_dest;
    assign ex_wen     = r_ex_wen;
    assign ex_pc      = r_ex_pc;
    assign o_dbg_busy = r_busy;

endmodule

// File: tb/tb_decode_issue_stage.sv
`timescale 1ns/1ps
module tb_decode_issue_stage;
  localparam int W = 146;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] ADDI5  = 32'h20050007; // addi r5,r0,7
  localparam logic [31:0] ADD6   = 32'h00A53020; // add  r6,r5,r5
  localparam logic [31:0] ORI3   = 32'h34038000; // ori  r3,r0,0x8000
  localparam logic [31:0] ADDI4  = 32'h20048000; // addi r4,r0,0x8000
  localparam logic [31:0] LUI5   = 32'h3C051234; // lui  r5,0x1234
  localparam logic [31:0] ADDI9  = 32'h20090001; // addi r9,r0,1
  localparam logic [31:0] ADD10  = 32'h01295020; // add  r10,r9,r9
  localparam logic [31:0] ADDR0  = 32'h00220020; // add  r0,r1,r2
  localparam logic [31:0] ADD3R0 = 32'h00001820; // add  r3,r0,r0
  localparam logic [31:0] JMP    = 32'h08000010; // j    0x10
  localparam logic [5:0] OPS [16] = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                      6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};

  // ---------------- clock / reset / DUT ----------------
  logic clock = 1'b0;
  logic reset;
  logic if_valid, if_ready, read_reg, ex_valid, ex_ready, ex_wen, wb_valid, flush;
  logic [31:0] if_instr, if_pc, data_1, data_2, ex_rs_val, ex_rt_val, ex_imm, ex_pc, wb_data;
  logic [31:0] o_dbg_busy;
  logic [4:0] RS, RT, ex_dest, wb_dest;
  logic [5:0] ex_op, ex_funct;

  always #5 clock = ~clock;

  decode_issue_stage dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .RS(RS), .RT(RT), .read_reg(read_reg), .data_1(data_1), .data_2(data_2),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_funct(ex_funct),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_dest(ex_dest),
    .ex_wen(ex_wen), .ex_pc(ex_pc), .wb_valid(wb_valid), .wb_dest(wb_dest),
    .wb_data(wb_data), .flush(flush), .o_dbg_busy(o_dbg_busy)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        wen;
    logic [31:0] pc;
  } ex_t;

  typedef struct packed {
    logic        rd_rs;
    logic        rd_rt;
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] imm;
  } dec_t;

  logic [W-1:0] exp_q[$];   // at most one entry: what the output register must hold
  logic [31:0]  m_busy;
  bit           m_ready;
  bit           m_xfer;
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic dec_t dec(input logic [31:0] ins);
    dec_t d;
    logic [5:0]  op;
    logic [31:0] sx, zx;
    op = ins[31:26];
    sx = 32'($signed(ins[15:0]));
    zx = 32'(ins[15:0]);
    d  = '0;
    if (op == 6'h00) begin
      d.rd_rs = 1; d.rd_rt = 1; d.wen = 1; d.dest = ins[15:11];
    end else if (op inside {[6'h08:6'h0B]} || op == 6'h23) begin
      d.rd_rs = 1; d.wen = 1; d.dest = ins[20:16]; d.imm = sx;
    end else if (op inside {[6'h0C:6'h0E]}) begin
      d.rd_rs = 1; d.wen = 1; d.dest = ins[20:16]; d.imm = zx;
    end else if (op == 6'h0F) begin
      d.wen = 1; d.dest = ins[20:16]; d.imm = zx << 16;
    end else if (op inside {6'h2B, 6'h04, 6'h05}) begin
      d.rd_rs = 1; d.rd_rt = 1; d.imm = sx;
    end else if (op == 6'h02) begin
      d.imm = {6'd0, ins[25:0]};
    end
    return d;
  endfunction

  function automatic bit wb_clears_now(input logic [4:0] r);
    return BYP && wb_valid && (wb_dest == r) && (r != 5'd0) && m_busy[r];
  endfunction

  function automatic bit blocks(input logic [4:0] r);
    ex_t f;
    if (r == 5'd0) return 1'b0;
    if (m_busy[r] && !wb_clears_now(r)) return 1'b1;
    if (exp_q.size() != 0) begin
      f = ex_t'(exp_q[0]);
      if (f.wen && f.dest == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit stall_of(input dec_t d);
    return (d.rd_rs && blocks(if_instr[25:21])) || (d.rd_rt && blocks(if_instr[20:16])) ||
           (d.wen && blocks(d.dest));
  endfunction

  function automatic logic [W-1:0] obs_pack();
    return {ex_op, ex_funct, ex_rs_val, ex_rt_val, ex_imm, ex_dest, ex_wen, ex_pc};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    op = OPS[$urandom_range(0, 15)];
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom), 6'($urandom)};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy);
    if_valid = v;  if_instr = ins; if_pc = $urandom; ex_ready = rdy;
    flush = 1'b0;  wb_valid = 1'b0; wb_dest = 5'd0; wb_data = $urandom;
    data_1 = $urandom; data_2 = $urandom;
  endtask

  // Called at a falling edge after inputs are set: compare everything.
  task automatic settle();
    dec_t d;
    #1;
    d = dec(if_instr);
    m_ready = !flush && !stall_of(d) && (exp_q.size() == 0 || ex_ready);
    chk("if_ready", W'(if_ready), W'(m_ready));
    chk("rs_addr", W'(RS), W'(if_instr[25:21]));
    chk("rt_addr", W'(RT), W'(if_instr[20:16]));
    chk("read_reg", W'(read_reg), W'(if_valid && (d.rd_rs || d.rd_rt)));
    chk("ex_valid", W'(ex_valid), W'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("ex_fields", obs_pack(), exp_q[0]);
    chk("busy", W'(o_dbg_busy), W'(m_busy));
  endtask

  // Advance the model by one clock, then move to the next falling edge.
  task automatic tick();
    dec_t d;
    ex_t  e, f;
    bit   ho;
    d  = dec(if_instr);
    m_xfer = if_valid && m_ready;
    ho = (exp_q.size() != 0) && ex_ready && !flush;
    e  = '0;
    if (m_xfer) begin
      e.op     = if_instr[31:26];
      e.funct  = if_instr[5:0];
      e.rs_val = (d.rd_rs && wb_clears_now(if_instr[25:21])) ? wb_data : data_1;
      e.rt_val = (d.rd_rt && wb_clears_now(if_instr[20:16])) ? wb_data : data_2;
      e.imm    = d.imm;
      e.dest   = d.dest;
      e.wen    = d.wen;
      e.pc     = if_pc;
    end
    if (wb_valid) m_busy[wb_dest] = 1'b0;
    if (ho) begin
      f = ex_t'(exp_q[0]);
      if (f.wen && f.dest != 5'd0) m_busy[f.dest] = 1'b1;
    end
    if (exp_q.size() != 0 && (flush || ho)) void'(exp_q.pop_front());
    if (m_xfer) exp_q.push_back(W'(e));
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reset asserted between edges: its effect must be visible immediately.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_ex_valid", W'(ex_valid), '0);
    chk("rst_ex_fields", obs_pack(), '0);
    chk("rst_busy", W'(o_dbg_busy), '0);
    exp_q.delete();
    m_busy = '0;
    m_xfer = 0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0);
    m_busy = '0;
    @(negedge clock);
    do_reset();

    // RAW on r5: stalls behind the output register, then behind the scoreboard.
    drive(1, ADDI5, 1); settle(); chk("addi_accept", W'(if_ready), W'(1)); tick();
    drive(1, ADD6, 1);  settle();
    chk("addi_imm", W'(ex_imm), W'(32'd7));
    chk("addi_dest", W'(ex_dest), W'(5'd5));
    chk("add_stall_ex", W'(if_ready), W'(0));
    tick();
    drive(1, ADD6, 1);  settle();
    chk("add_stall_busy", W'(if_ready), W'(0));
    chk("busy5_set", W'(o_dbg_busy[5]), W'(1));
    tick();
    drive(1, ADD6, 1); wb_valid = 1; wb_dest = 5'd5; wb_data = 32'hCAFE0005;
    settle(); chk("add_wb_cycle", W'(if_ready), W'(BYP)); tick();
    if (BYP) begin
      drive(0, 32'd0, 1); settle();
      chk("byp_rs_val", W'(ex_rs_val), W'(32'hCAFE0005));
      chk("byp_rt_val", W'(ex_rt_val), W'(32'hCAFE0005));
      tick();
    end else begin
      drive(1, ADD6, 1); settle(); chk("add_after_wb", W'(if_ready), W'(1)); tick();
      drive(0, 32'd0, 1); settle(); chk("add_issued", W'(ex_valid), W'(1)); tick();
    end

    // Immediate forms and output-register hold under backpressure.
    do_reset();
    drive(1, ORI3, 0); settle(); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, ADDI4, 0); settle();
      chk("hold_if_ready", W'(if_ready), W'(0));
      chk("ori_imm", W'(ex_imm), W'(32'h00008000));
      tick();
    end
    drive(1, ADDI4, 1); settle(); chk("release_ready", W'(if_ready), W'(1)); tick();
    drive(1, LUI5, 1);  settle();
    chk("b2b_valid", W'(ex_valid), W'(1));
    chk("addi_sext", W'(ex_imm), W'(32'hFFFF8000));
    tick();
    drive(0, 32'd0, 1); settle(); chk("lui_imm", W'(ex_imm), W'(32'h12340000)); tick();

    // Flush drops the entry without marking its destination busy.
    do_reset();
    drive(1, ADDI9, 1); settle(); tick();
    drive(0, 32'd0, 1); flush = 1; settle(); chk("flush_if_ready", W'(if_ready), W'(0)); tick();
    drive(1, ADD10, 1); settle();
    chk("flush_ex_valid", W'(ex_valid), W'(0));
    chk("flush_busy9", W'(o_dbg_busy[9]), W'(0));
    chk("r9_reader_ready", W'(if_ready), W'(1));
    tick();

    // r0 never becomes busy and never stalls.
    do_reset();
    drive(1, ADDR0, 1); settle(); tick();
    drive(1, ADD3R0, 1); settle(); chk("r0_no_stall", W'(if_ready), W'(1)); tick();
    drive(0, 32'd0, 1); settle(); chk("r0_not_busy", W'(o_dbg_busy[0]), W'(0)); tick();

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    drive(0, 32'd0, 1);
    for (int c = 0; c < 3000; c++) begin
      if (!if_valid || m_xfer) begin
        if_valid = ($urandom_range(0, 9) < 8);
        if_instr = rand_instr();
        if_pc    = $urandom;
      end
      ex_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_dest  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      data_1   = $urandom;
      data_2   = $urandom;
      settle();
      tick();
    end

    // Reset with an instruction in flight.
    drive(1, JMP, 1); settle(); chk("pre_rst_accept", W'(if_ready), W'(1)); tick();
    drive(1, JMP, 0); settle(); chk("pre_rst_valid", W'(ex_valid), W'(1));
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Instruction decode/issue stage directly upstream of the 32x32 register bank.
- Takes fetched instructions from IF, extracts fields, drives bank read addresses, and captures the bank's operands together with the decoded control.
- Tracks pending register writes in a scoreboard and stalls on RAW/WAW hazards.
- Hands one instruction per cycle to EX over a valid/ready pipeline register.

Parameters:
DATA_WIDTH, 32, operand/immediate/PC width
NUM_REGS, 32, scoreboard depth; register address is log2(NUM_REGS)=5 bits
ZERO_REG_HARDWIRED, 1, 1: register 0 is never marked busy and never causes a stall

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-high
if_valid  in  1  IF presents an instruction
if_ready  out  1  stage accepts the instruction this cycle
if_instr  in  32  instruction word
if_pc  in  DATA_WIDTH  PC of if_instr
RS  out  5  bank read address 1 = if_instr[25:21] (combinational)
RT  out  5  bank read address 2 = if_instr[20:16] (combinational)
read_reg  out  1  high when if_valid and the decoded op reads a register
data_1  in  DATA_WIDTH  bank read data for RS, valid same cycle
data_2  in  DATA_WIDTH  bank read data for RT, valid same cycle
ex_valid  out  1  output register holds an instruction
ex_ready  in  1  EX accepts it
ex_op  out  6  opcode
ex_funct  out  6  funct field
ex_rs_val  out  DATA_WIDTH  captured data_1
ex_rt_val  out  DATA_WIDTH  captured data_2
ex_imm  out  DATA_WIDTH  extended immediate
ex_dest  out  5  destination register
ex_wen  out  1  instruction writes ex_dest
ex_pc  out  DATA_WIDTH  captured PC
wb_valid  in  1  writeback completes this cycle
wb_dest  in  5  register written by WB
wb_data  in  DATA_WIDTH  WB value; used only with WB_BYPASS_EN
flush  in  1  drop the instruction in the output register; deassert if_ready

Behaviour:
- Reset (async): busy vector = 0. ex_valid = 0. ex_op, ex_funct, ex_rs_val, ex_rt_val, ex_imm, ex_dest, ex_wen, ex_pc = 0.
- Decode:
  - op 0x00 (R-type): reads rs and rt; dest = instr[15:11]; wen = 1.
  - op 0x08-0x0B (addi/addiu/slti/sltiu): reads rs; dest = rt; imm sign-extended.
  - op 0x0C-0x0E (andi/ori/xori): reads rs; dest = rt; imm zero-extended.
  - op 0x0F (lui): no read; dest = rt; imm = {instr[15:0], 16'b0}.
  - op 0x23 (lw): reads rs; dest = rt; wen = 1; imm sign-extended.
  - op 0x2B (sw), 0x04 (beq), 0x05 (bne): read rs and rt; wen = 0; imm sign-extended.
  - op 0x02 (j): no read; wen = 0; imm = zero-extended instr[25:0].
  - Any other op: issued as NOP with wen = 0 and no reads.
- Hazard: stall = any read source, or the destination when wen = 1, is non-zero and either:
  - its busy bit is set, or
  - it equals ex_dest while ex_valid and ex_wen.
- if_ready = !flush && !stall && (!ex_valid || ex_ready). A transfer occurs when if_valid && if_ready. On transfer, the output register loads all ex_* fields, and the operands are captured from data_1/data_2 in the same cycle.
- Latency: 1 cycle from IF acceptance to ex_valid.
- Output register:
  - Holds all fields stable while ex_valid && !ex_ready.
  - Clears ex_valid on handoff with no new transfer.
  - Back-to-back transfer keeps ex_valid = 1.
- Scoreboard:
  - On EX handoff (ex_valid && ex_ready && !flush) with ex_wen and ex_dest != 0, set busy[ex_dest].
  - wb_valid clears busy[wb_dest].
  - If set and clear hit the same register in the same cycle, set wins.
  - A WB clear is visible to the hazard check only on the next cycle; there is no same-cycle bypass.
- flush: ex_valid <= 0 next cycle; no busy bit is set; busy bits already set are untouched; if_ready = 0 that cycle.
- flush together with an ex_ready handoff: flush wins, and the instruction is not counted as handed off.
- Reset mid-operation: all state is lost immediately; the in-flight instruction is discarded.

Optional Feature:
WB_BYPASS_EN:
- Defined: if wb_valid && wb_dest != 0 matches a source whose busy bit is set, that source is treated as not busy this cycle, and wb_data replaces data_1/data_2 in the captured operand. The WAW check also honours the same-cycle clear.
- Undefined: wb_data is ignored, and a cleared register is usable one cycle after wb_valid.

Test Plan:
- Reset mid-stream with ex_valid=1 -> ex_valid=0 and busy=0 immediately; every ex_* output = 0.
- addi r5,r0,7 (0x20050007) then add r6,r5,r5 -> first issues with ex_dest=5, ex_imm=7; second stalls (if_ready=0) until wb_valid/wb_dest=5, then issues the cycle after (same cycle with WB_BYPASS_EN, ex_rs_val=wb_data).
- ori r3,r0,0x8000 -> ex_imm=0x00008000; addi r3,r0,0x8000 -> ex_imm=0xFFFF8000; lui r3,0x1234 -> ex_imm=0x12340000.
- ex_ready=0 for 3 cycles with if_valid=1 -> ex_* stable, if_ready=0; ex_ready=1 -> back-to-back issue, ex_valid stays 1.
- flush with ex_valid=1, ex_wen=1, ex_dest=9 -> ex_valid=0 next cycle, busy[9]=0, a following reader of r9 issues without stall.
- add r0,r1,r2 then add r3,r0,r0 -> no busy bit set for r0, no stall.
